// File: rtl/ram_boot_pkg.sv
// Shared types and constants for the RAM boot loader.
package ram_boot_pkg;

  typedef enum logic [3:0] {
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    DATA_WAIT,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    VEC_LO,
    VEC_HI,
    DONE
  } state_t;

  localparam logic [15:0] VEC_ADDR_LO = 16'hFFFC;
  localparam logic [15:0] VEC_ADDR_HI = 16'hFFFD;
  localparam int unsigned HDR_BYTES   = 4;

  // Header states are encoded first, one per header byte.
  function automatic logic is_hdr(state_t s);
    return 32'(s) < HDR_BYTES;
  endfunction

endpackage

// File: rtl/ram_boot_loader_if.sv
// Boot stream, CPU bus and RAM bus bundle for the RAM boot loader.
interface ram_boot_loader_if;

  logic [7:0]  i_in_data;
  logic        i_in_valid;
  logic        o_in_ready;

  logic [15:0] i_cpu_addr;
  logic        i_cpu_enable_x;
  logic        i_cpu_write_x;
  logic [7:0]  i_cpu_data;
  logic [7:0]  o_cpu_data;

  logic [15:0] o_ram_addr;
  logic        o_ram_enable_x;
  logic        o_ram_write_x;
  logic [7:0]  o_ram_data;
  logic [7:0]  i_ram_data;

  logic        o_cpu_reset;
  logic        o_done;

  modport master (
    input  i_in_data, i_in_valid,
    input  i_cpu_addr, i_cpu_enable_x, i_cpu_write_x, i_cpu_data,
    input  i_ram_data,
    output o_in_ready, o_cpu_data,
    output o_ram_addr, o_ram_enable_x, o_ram_write_x, o_ram_data,
    output o_cpu_reset, o_done
  );

  modport slave (
    output i_in_data, i_in_valid,
    output i_cpu_addr, i_cpu_enable_x, i_cpu_write_x, i_cpu_data,
    output i_ram_data,
    input  o_in_ready, o_cpu_data,
    input  o_ram_addr, o_ram_enable_x, o_ram_write_x, o_ram_data,
    input  o_cpu_reset, o_done
  );

endinterface

// File: rtl/ram_wr_strobe.sv
// SETUP / STROBE / HOLD timing for one RAM byte write.
module ram_wr_strobe
  import ram_boot_pkg::*;
#(
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic enable_x,
  output logic write_x,
  output logic done
);

  localparam logic [3:0] CNT_LOAD = 4'(WR_CYCLES - 1);

  state_t     phase;
  logic       busy;
  logic [3:0] cnt;

  // Done is high during the HOLD cycle so the loader can move on at its end.
  assign done = busy && (phase == WR_HOLD);

  // Sequence enable/write strobes; write_x stays low for WR_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      phase    <= WR_SETUP;
      cnt      <= '0;
      enable_x <= 1'b1;
      write_x  <= 1'b1;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        phase    <= WR_SETUP;
        enable_x <= 1'b0;
      end
    end else begin
      case (phase)
        WR_SETUP: begin
          phase   <= WR_STROBE;
          write_x <= 1'b0;
          cnt     <= CNT_LOAD;
        end
        WR_STROBE: begin
          if (cnt == '0) begin
            phase   <= WR_HOLD;
            write_x <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          busy     <= 1'b0;
          enable_x <= 1'b1;
        end
        default: begin
          busy     <= 1'b0;
          enable_x <= 1'b1;
          write_x  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_boot_loader.sv
// Loads a byte-stream program image into RAM, writes the reset vector,
// then hands the RAM bus to the CPU and releases CPU reset.
module ram_boot_loader
  import ram_boot_pkg::*;
#(
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned VEC_EN    = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  ram_boot_loader_if.master  bus
);

  // Where the load goes once the data bytes are exhausted.
  localparam state_t TAIL      = (VEC_EN != 0) ? VEC_LO : DONE;
  localparam logic   TAIL_DONE = (VEC_EN == 0);

  state_t      state;
  state_t      after_wr;
  logic [15:0] load_addr;
  logic [15:0] cur_addr;
  logic [15:0] remaining;
  logic [15:0] addr_r;
  logic [7:0]  wdata_r;
  logic        in_ready;
  logic        done_r;
  logic        cpu_reset_r;

  logic        accept;
  logic        wr_start;
  logic        wr_done;
  logic        wr_enable_x;
  logic        wr_write_x;

  assign accept   = in_ready && bus.i_in_valid;
  assign wr_start = (state == DATA_WAIT && accept) || (state == VEC_LO) || (state == VEC_HI);

  ram_wr_strobe #(
    .WR_CYCLES (WR_CYCLES)
  ) u_wr_strobe (
    .clk      (i_clk),
    .rst      (i_reset),
    .start    (wr_start),
    .enable_x (wr_enable_x),
    .write_x  (wr_write_x),
    .done     (wr_done)
  );

  // Loader state machine: header parse, per-byte write dispatch, vector, handoff.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= HDR0;
      after_wr    <= HDR0;
      load_addr   <= '0;
      cur_addr    <= '0;
      remaining   <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      in_ready    <= 1'b0;
      done_r      <= 1'b0;
      cpu_reset_r <= 1'b1;
    end else if (is_hdr(state)) begin
      in_ready <= 1'b1;
      if (accept) begin
        case (state)
          HDR0: begin
            load_addr[7:0] <= bus.i_in_data;
            state          <= HDR1;
          end
          HDR1: begin
            load_addr[15:8] <= bus.i_in_data;
            cur_addr        <= {bus.i_in_data, load_addr[7:0]};
            state           <= HDR2;
          end
          HDR2: begin
            remaining[7:0] <= bus.i_in_data;
            state          <= HDR3;
          end
          default: begin
            remaining[15:8] <= bus.i_in_data;
            if ({bus.i_in_data, remaining[7:0]} != '0) begin
              state <= DATA_WAIT;
            end else begin
              in_ready    <= 1'b0;
              state       <= TAIL;
              done_r      <= TAIL_DONE;
              cpu_reset_r <= !TAIL_DONE;
            end
          end
        endcase
      end
    end else begin
      case (state)
        DATA_WAIT: begin
          if (accept) begin
            addr_r   <= cur_addr;
            wdata_r  <= bus.i_in_data;
            after_wr <= DATA_WAIT;
            in_ready <= 1'b0;
            state    <= WR_SETUP;
          end
        end
        VEC_LO: begin
          addr_r   <= VEC_ADDR_LO;
          wdata_r  <= load_addr[7:0];
          after_wr <= VEC_HI;
          state    <= WR_SETUP;
        end
        VEC_HI: begin
          addr_r   <= VEC_ADDR_HI;
          wdata_r  <= load_addr[15:8];
          after_wr <= DONE;
          state    <= WR_SETUP;
        end
        // The strobe block walks SETUP/STROBE/HOLD; the loader parks here
        // until it reports the end of HOLD.
        WR_SETUP, WR_STROBE, WR_HOLD: begin
          if (wr_done) begin
            if (after_wr == DATA_WAIT) begin
              cur_addr  <= cur_addr + 16'd1;
              remaining <= remaining - 16'd1;
              if (remaining != 16'd1) begin
                state    <= DATA_WAIT;
                in_ready <= 1'b1;
              end else begin
                state       <= TAIL;
                done_r      <= TAIL_DONE;
                cpu_reset_r <= !TAIL_DONE;
              end
            end else begin
              state       <= after_wr;
              done_r      <= (after_wr == DONE);
              cpu_reset_r <= (after_wr != DONE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Once loaded, the CPU drives the RAM directly.
  assign bus.o_ram_addr     = done_r ? bus.i_cpu_addr     : addr_r;
  assign bus.o_ram_enable_x = done_r ? bus.i_cpu_enable_x : wr_enable_x;
  assign bus.o_ram_write_x  = done_r ? bus.i_cpu_write_x  : wr_write_x;
  assign bus.o_ram_data     = done_r ? bus.i_cpu_data     : wdata_r;
  assign bus.o_cpu_data     = bus.i_ram_data;
  assign bus.o_in_ready     = in_ready;
  assign bus.o_done         = done_r;
  assign bus.o_cpu_reset    = cpu_reset_r;

endmodule

// File: doc/ram_boot_loader.md
Name: ram_boot_loader

Overview:
- Upstream master for the 64Kx8 system RAM. Sits between the byte-stream boot source (UART receiver), the 6502 core bus, and the RAM.
- After reset it owns the RAM bus and receives a program image as a stream of bytes. It writes the image into RAM with correctly timed active-low enable/write strobes, then writes the reset vector.
- When loading is complete it hands the RAM bus to the CPU and releases CPU reset.

Parameters:
- WR_CYCLES, 2, number of clock cycles o_ram_write_x is held low per byte; range 1..15.
- VEC_EN, 1, when 1 the reset vector at $FFFC/$FFFD is written with the load address after the data; when 0 that step is skipped.

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_in_data  in  8  boot stream byte
- i_in_valid  in  1  i_in_data is valid
- o_in_ready  out  1  loader accepts a byte; transfer occurs when valid and ready are both high at a rising edge
- i_cpu_addr  in  16  CPU address
- i_cpu_enable_x  in  1  CPU RAM enable, active low
- i_cpu_write_x  in  1  CPU write, active low
- i_cpu_data  in  8  CPU write data
- o_cpu_data  out  8  read data to CPU; always equals i_ram_data
- o_ram_addr  out  16  RAM address
- o_ram_enable_x  out  1  RAM enable, active low
- o_ram_write_x  out  1  RAM write, active low
- o_ram_data  out  8  RAM write data
- i_ram_data  in  8  RAM read data
- o_cpu_reset  out  1  active-high reset to the 6502 core
- o_done  out  1  load complete; CPU owns the bus

Behaviour:
- Reset (async, active high) forces the following, and holds them while i_reset is high:
  - state = HDR0; loader registers = 0
  - o_ram_enable_x = 1, o_ram_write_x = 1, o_ram_addr = 0, o_ram_data = 0
  - o_in_ready = 0, o_done = 0, o_cpu_reset = 1
- Reset asserted mid-load aborts the load immediately; no partial-vector recovery is attempted.
- Stream format, little-endian: byte 0 = load address lo, byte 1 = load address hi, byte 2 = length lo, byte 3 = length hi, then `length` data bytes.
- o_in_ready is a registered output. It is high only in states HDR0..HDR3 and DATA_WAIT, so the first accept is possible on the second rising edge after reset deassertion.
- State machine:
  - HDR0..HDR3: on accept, latch the byte into load_addr or len and advance. HDR3 goes to DATA_WAIT if len != 0. If len == 0 it goes to VEC_LO when VEC_EN = 1, otherwise to DONE.
  - DATA_WAIT: on accept, set o_ram_addr = cur_addr and o_ram_data = the byte, then go to WR_SETUP. cur_addr is initialised to load_addr in HDR1 → HDR2.
  - WR_SETUP (1 cycle): o_ram_enable_x = 0, o_ram_write_x = 1.
  - WR_STROBE (WR_CYCLES cycles, internal counter): o_ram_enable_x = 0, o_ram_write_x = 0.
  - WR_HOLD (1 cycle): o_ram_write_x = 1, o_ram_enable_x = 0. Address and data remain stable through SETUP/STROBE/HOLD. On exit, o_ram_enable_x returns to 1, cur_addr increments, remaining decrements.
  - After WR_HOLD: if remaining != 0, go to DATA_WAIT. Otherwise go to VEC_LO (VEC_EN = 1) or DONE.
  - VEC_LO / VEC_HI: write load_addr[7:0] to $FFFC, then load_addr[15:8] to $FFFD, each using the same SETUP/STROBE/HOLD sequence. Then go to DONE.
  - DONE: terminal until reset. o_done = 1 and o_cpu_reset = 0, both registered, on the cycle of entry.
- Throughput: one data byte per WR_CYCLES + 3 cycles, with ready asserted one of those cycles.
- Address arithmetic is 16-bit modulo: $FFFF + 1 wraps to $0000. A load that overlaps $FFFC/$FFFD is overwritten by the vector write when VEC_EN = 1.
- Bus mux:
  - Not DONE: the CPU is ignored; RAM signals come from loader registers.
  - DONE: combinational pass-through: o_ram_addr = i_cpu_addr, o_ram_enable_x = i_cpu_enable_x, o_ram_write_x = i_cpu_write_x, o_ram_data = i_cpu_data.
- i_in_valid while o_in_ready = 0 has no effect; the source must hold the byte. Bytes offered in DONE are never accepted.

Decomposition:
- Shared package (ram_boot_pkg):
  - state enumeration (HDR0..HDR3, DATA_WAIT, WR_SETUP, WR_STROBE, WR_HOLD, VEC_LO, VEC_HI, DONE)
  - constants VEC_ADDR_LO = 16'hFFFC and VEC_ADDR_HI = 16'hFFFD
  - constant HDR_BYTES = 4
- Sub-module ram_wr_strobe: takes a start pulse, drives the SETUP/STROBE/HOLD timing with the WR_CYCLES counter, and returns a done pulse. It is reused for both data and vector writes.

Test Plan:
- Reset then stream 00 02 03 00 A9 01 60 (WR_CYCLES = 2) → RAM $0200 = A9, $0201 = 01, $0202 = 60, $FFFC = 00, $FFFD = 02. o_done and o_cpu_reset = 0 rise after the $FFFD write. Each byte shows write_x low for exactly 2 cycles, with enable_x low 1 cycle before and 1 cycle after.
- Header FE FF 04 00, data 11 22 33 44, VEC_EN = 0 → $FFFE = 11, $FFFF = 22, $0000 = 33, $0001 = 44 (wrap). No vector write; DONE follows the last HOLD.
- Header 00 80 00 00 (len 0) → no data writes; $FFFC = 00, $FFFD = 80; o_done = 1.
- Source toggles i_in_valid randomly and holds valid during WR_* states → a byte is accepted only when ready = 1; no byte is lost or duplicated; RAM contents match the stream exactly.
- Assert i_reset during WR_STROBE of the second data byte → outputs return immediately to reset values (enable_x = 1, write_x = 1, cpu_reset = 1). A fresh stream after release loads correctly.
- After DONE, the CPU writes 5A to $1234 then reads it → o_ram_* mirrors the i_cpu_* inputs combinationally and o_cpu_data = 5A.
